// File: rtl/pdm_pkg.sv
// Shared PDM peripheral constants: sample width, FIFO depth,
// bus register offsets and the STATUS register layout.
package pdm_pkg;

  localparam int PCM_WIDTH  = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_LW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [4:0] REG_ENABLE = 5'h00;
  localparam logic [4:0] REG_PERIOD = 5'h04;
  localparam logic [4:0] REG_SAMPLE = 5'h08;
  localparam logic [4:0] REG_SELECT = 5'h0C;
  localparam logic [4:0] REG_STATUS = 5'h10;
  localparam logic [4:0] REG_THRESH = 5'h14;

  typedef struct packed {
    logic               irq;
    logic               overflow;
    logic               full;
    logic               empty;
    logic [FIFO_LW-1:0] level;
  } status_t;

endpackage

// File: rtl/pdm_pcm_fifo_if.sv
// Sample FIFO bus bundle: push strobe from the decimator, pop and
// config from the register file, FIFO status back (master drives in).
interface pdm_pcm_fifo_if
  import pdm_pkg::*;
#(
  parameter int WIDTH = PCM_WIDTH,
  parameter int LW    = FIFO_LW
);

  logic             enable;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             pop;
  logic             clear;
  logic [LW-1:0]    threshold;
  logic [WIDTH-1:0] data_out;
  logic [LW-1:0]    level;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             irq;

  modport master (
    output enable, sample_in, sample_valid,
    output pop, clear, threshold,
    input  data_out, level, empty,
    input  full, overflow, irq
  );

  modport slave (
    input  enable, sample_in, sample_valid,
    input  pop, clear, threshold,
    output data_out, level, empty,
    output full, overflow, irq
  );

endinterface

// File: rtl/pdm_pcm_fifo.sv
// Show-ahead PCM sample FIFO, drop-on-full with sticky overflow,
// registered threshold irq. Ports: clk, rst_n, bus (slave modport).
module pdm_pcm_fifo
  import pdm_pkg::*;
#(
  parameter int WIDTH = PCM_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pdm_pcm_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;

  logic is_empty, is_full;
  logic push_req, pop_ok, push_ok;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LW'(DEPTH));

  always_comb begin
    push_req = bus.sample_valid & bus.enable & ~bus.clear;
    pop_ok   = bus.pop & ~is_empty & ~bus.clear;
    // a pop in the same cycle frees the slot a full push needs
    push_ok  = push_req & (~is_full | pop_ok);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (bus.clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop_ok)
        rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok)
        wr_ptr_d = wr_ptr_q + PW'(1);
      level_d = level_q + LW'(push_ok)
                        - LW'(pop_ok);
      if (push_req & ~push_ok)
        ovf_d = 1'b1;
    end

    // from next-state so irq lines up with the new level
    irq_d = ovf_d
          | ((bus.threshold != '0)
             & (level_d >= bus.threshold));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // storage holds no reset; stale entries are never visible
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= bus.sample_in;
  end

  assign bus.data_out = is_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.level    = level_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.overflow = ovf_q;
  assign bus.irq      = irq_q;

endmodule

// File: doc/pdm_pcm_fifo.md
# pdm_pcm_fifo

Sample buffer between the PDM peripheral's CIC decimator output and the TinyQV bus register file. It accepts 16-bit PCM samples on a single-cycle strobe, stores up to DEPTH of them in a show-ahead FIFO, and drops new samples on overflow, setting a sticky flag. It raises a level-triggered interrupt at a programmable fill threshold. Firmware can therefore drain bursts of samples per interrupt instead of taking one interrupt per sample.

## Interface
Parameters:
- WIDTH, 16, sample width in bits
- DEPTH, 8, number of entries; power of two, minimum 2
- LW, $clog2(DEPTH)+1, width of level/threshold fields

Ports:
- clk  in  1  system clock (64 MHz nominal)
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- enable  in  1  when 0, pushes are ignored; stored contents and pops are unaffected
- sample_in  in  WIDTH  PCM sample from the decimator, two's complement
- sample_valid  in  1  single-cycle push strobe, synchronous to clk
- pop  in  1  single-cycle read strobe from the bus decode (32-bit read of the sample register)
- clear  in  1  synchronous flush
- threshold  in  LW  interrupt fill level; 0 disables the threshold interrupt
- data_out  out  WIDTH  head entry (show-ahead); 0 when empty
- level  out  LW  number of stored entries, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- overflow  out  1  sticky flag: a sample was dropped
- irq  out  1  interrupt request, registered

## Operation
- Storage: DEPTH x WIDTH register array with read pointer rd_ptr, write pointer wr_ptr and occupancy count, all clocked.
- Push condition: sample_valid & enable & !clear. If !full, or if full with an accepted pop in the same cycle, write mem[wr_ptr] and advance wr_ptr.
- Push while full without a pop: the sample is dropped, overflow is set to 1, and existing contents are unchanged.
- Pop condition: pop & !empty & !clear. rd_ptr advances. A pop while empty is ignored and has no side effect.
- Simultaneous push and pop: both take effect, level is unchanged, and overflow is not set, even when full. When empty, the pop is ignored and the push proceeds, so level becomes 1.
- clear has priority over push and pop. It zeros the pointers, level and overflow. A sample_valid arriving in the same cycle is discarded.
- Pointers wrap modulo DEPTH. level is held in a separate counter, so full and empty never alias.
- data_out = mem[rd_ptr] when !empty, else 0.
- irq is registered. Next value = overflow_next | (threshold != 0 & level_next >= threshold). irq deasserts only by draining below threshold or by clear. A threshold greater than DEPTH never fires except through overflow.

## Timing
- Reset (asynchronous): pointers, level, overflow and irq go to 0. data_out = 0, empty = 1, full = 0. Memory contents are don't-care.
- Push at edge N: the sample is readable on data_out and counted in level after edge N, so it is visible in cycle N+1. irq reflects the new level in the same cycle N+1, because irq is computed from next-state values.
- Pop at edge N: data_out shows the next entry, or 0, after edge N. The bus samples data_out in the same cycle pop is asserted, before the edge.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation: all state clears immediately without waiting for a clock edge. Samples are lost.
- Holding sample_valid high for multiple cycles pushes once per cycle. Upstream guarantees a single-cycle pulse.

## Structure
- Shared package pdm_pkg holds PCM_WIDTH = 16, FIFO_DEPTH = 8, and the register offsets (ENABLE 0x0, PERIOD 0x4, SAMPLE 0x8, SELECT 0xC, STATUS 0x10, THRESH 0x14). STATUS packs {irq, overflow, full, empty, level}.
- One module. Pointer/count logic is inline, with no sub-module needed. Memory is a flop array; no SRAM macro at this size.

## Test plan
- Reset, then push 0x1234, 0x8000, 0x7FFF at DEPTH = 8: level = 3, data_out = 0x1234; three pops return them in order, then empty = 1 and data_out = 0.
- Push 9 samples 0x0001..0x0009 with no pops: full = 1, level = 8, overflow = 1, irq = 1; draining returns 0x0001..0x0008; clear then drops overflow and irq.
- threshold = 4: irq stays 0 through 3 pushes, rises in the cycle after the 4th push, and falls in the cycle after the pop that brings level to 3.
- Full FIFO with push (0xAAAA) and pop in the same cycle: level stays 8, overflow stays 0, and the last entry read back is 0xAAAA.
- Empty FIFO with simultaneous pop and push of 0x5555: level = 1, data_out = 0x5555. clear and push in the same cycle leave level = 0.
- enable = 0 with 3 strobes: level stays 0. Asserting rst_n low mid-burst between clock edges zeros level, irq and overflow immediately.
